// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline sequencer for the 5-stage core.
//  Merges ID/EX/MEM stall requests into a per-stage freeze vector and turns
//  exceptions or a stuck-stall watchdog into a single-cycle flush with a
//  redirect PC.
// Ports:
//  clk, rst             clock / synchronous active-high reset
//  stallreq_id/ex/mem   per-stage hold requests
//  excp_valid, excp_pc  exception committed in MEM and its handler address
//  stall[5:0]           freeze vector [0]pc [1]if [2]id [3]ex [4]mem [5]wb (combinational)
//  flush, new_pc        one-cycle pipeline clear and redirect target
//  stall_timeout        sticky watchdog-fired flag
//  stall_cnt            consecutive stall cycle count
module pipe_ctrl #(
  parameter int          STALL_LIMIT    = 256,
  parameter int          CNT_W          = 9,
  parameter logic [31:0] TIMEOUT_VECTOR = 32'h0000_0180
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic             excp_valid,
  input  logic [31:0]      excp_pc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_LIMIT - 1);

  state_t           state_q;
  logic             flush_q;
  logic [31:0]      new_pc_q;
  logic             timeout_q;
  logic [CNT_W-1:0] cnt_q;
  logic             any_req;

  assign any_req = stallreq_id | stallreq_ex | stallreq_mem;

  // Zero-latency freeze: the requesting stage and everything upstream hold.
  // A committing exception must not hold the faulting instruction, and the
  // flush cycle ignores all requests.
  always_comb begin
    stall = 6'b000000;
    if (state_q != FLUSH && !excp_valid) begin
      if (stallreq_mem)     stall = 6'b011111;
      else if (stallreq_ex) stall = 6'b001111;
      else if (stallreq_id) stall = 6'b000111;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      flush_q   <= 1'b0;
      new_pc_q  <= 32'h0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      flush_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (excp_valid) begin
            state_q  <= FLUSH;
            flush_q  <= 1'b1;
            new_pc_q <= excp_pc;
          end else if (any_req) begin
            state_q <= STALL;
            cnt_q   <= CNT_W'(1);
          end
        end
        STALL: begin
          if (excp_valid) begin
            state_q  <= FLUSH;
            flush_q  <= 1'b1;
            new_pc_q <= excp_pc;
            cnt_q    <= '0;
          end else if (!any_req) begin
            state_q <= RUN;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            // Watchdog: a stall this long is treated as a hung unit.
            state_q   <= FLUSH;
            flush_q   <= 1'b1;
            new_pc_q  <= TIMEOUT_VECTOR;
            timeout_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign flush         = flush_q;
  assign new_pc        = new_pc_q;
  assign stall_timeout = timeout_q;
  assign stall_cnt     = cnt_q;

endmodule
